// File: rtl/merger_stream.sv
`default_nettype none
// ============================================================================
// Module      : merger_stream
// Description : RADIX-way streaming merger for an SpGEMM merge tree. Takes
//               RADIX sorted (coordinate, value) streams and emits a single
//               stream in ascending coordinate order through a registered,
//               back-pressurable output stage. Equal coordinates are either
//               summed into one output element (MERGER_ACCUMULATE=1) or
//               passed through one at a time in lane order (MERGER_ACCUMULATE=0).
//
// Ports       : clock      - sole clock, all state updates on rising edge
//               reset      - synchronous, active-low reset
//               in_valid   - per-lane element valid             [RADIX]
//               in_coord   - lane i at [i*COORD_BITS +: COORD_BITS]
//               in_value   - lane i at [i*VALUE_BITS +: VALUE_BITS]
//               in_last    - element is final one of its lane   [RADIX]
//               in_ready   - lane element consumed this cycle   [RADIX]
//               out_valid  - output element valid
//               out_coord  - merged coordinate
//               out_value  - value (sum when accumulated)
//               out_last   - final element of the merged round
//               out_ready  - downstream accepts output
//               busy       - some lane finished, round still open
//
// Revision    : 1.0 - initial release
// ============================================================================
module merger_stream #(
    parameter int MERGER_RADIX      = 4,
    parameter int MERGER_COORD_BITS = 8,
    parameter int MERGER_VALUE_BITS = 16,
    parameter int MERGER_ACCUMULATE = 1
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [MERGER_RADIX-1:0]                   in_valid,
    input  logic [MERGER_RADIX*MERGER_COORD_BITS-1:0] in_coord,
    input  logic [MERGER_RADIX*MERGER_VALUE_BITS-1:0] in_value,
    input  logic [MERGER_RADIX-1:0]                   in_last,
    output logic [MERGER_RADIX-1:0]                   in_ready,
    output logic                                      out_valid,
    output logic [MERGER_COORD_BITS-1:0]              out_coord,
    output logic [MERGER_VALUE_BITS-1:0]              out_value,
    output logic                                      out_last,
    input  logic                                      out_ready,
    output logic                                      busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [MERGER_RADIX-1:0]      r_done;
    logic                         r_out_valid;
    logic [MERGER_COORD_BITS-1:0] r_out_coord;
    logic [MERGER_VALUE_BITS-1:0] r_out_value;
    logic                         r_out_last;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [MERGER_COORD_BITS-1:0] w_coord [MERGER_RADIX];
    logic [MERGER_VALUE_BITS-1:0] w_value [MERGER_RADIX];
    logic [MERGER_RADIX-1:0]      w_active;
    logic [MERGER_RADIX-1:0]      w_eq;
    logic [MERGER_RADIX-1:0]      w_sel;
    logic [MERGER_RADIX-1:0]      w_done_next;
    logic [MERGER_COORD_BITS-1:0] w_min;
    logic [MERGER_VALUE_BITS-1:0] w_sum;
    logic                         w_all_valid;
    logic                         w_out_free;
    logic                         w_pop;
    logic                         w_round_end;

    assign w_active = ~r_done;

    // A lane that already delivered its last element never blocks a pop;
    // every still-active lane must present a head so the minimum is exact.
    assign w_all_valid = &(in_valid | r_done);
    assign w_out_free  = ~r_out_valid | out_ready;
    assign w_pop       = reset & w_all_valid & w_out_free;

    genvar gi;
    generate
        for (gi = 0; gi < MERGER_RADIX; gi++) begin : g_lane
            assign w_coord[gi] = in_coord[gi*MERGER_COORD_BITS +: MERGER_COORD_BITS];
            assign w_value[gi] = in_value[gi*MERGER_VALUE_BITS +: MERGER_VALUE_BITS];
            assign w_eq[gi]    = w_active[gi] && (w_coord[gi] == w_min);
        end
    endgenerate

    // Smallest head coordinate among active lanes. Starting from all-ones
    // keeps the maximum coordinate value selectable.
    always_comb begin
        w_min = '1;
        for (int i = 0; i < MERGER_RADIX; i++) begin
            if (w_active[i] && (w_coord[i] < w_min)) begin
                w_min = w_coord[i];
            end
        end
    end

    generate
        if (MERGER_ACCUMULATE != 0) begin : g_accumulate
            // Every lane at the minimum is consumed together.
            assign w_sel = w_eq;
        end else begin : g_first_only
            // Only the lowest-index lane at the minimum is consumed, so
            // duplicates leave in lane order across successive cycles.
            logic w_seen;
            always_comb begin
                w_sel  = '0;
                w_seen = 1'b0;
                for (int i = 0; i < MERGER_RADIX; i++) begin
                    if (w_eq[i] && !w_seen) begin
                        w_sel[i] = 1'b1;
                        w_seen   = 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Sum wraps modulo 2^VALUE_BITS by construction of the accumulator width.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < MERGER_RADIX; i++) begin
            if (w_sel[i]) begin
                w_sum = w_sum + w_value[i];
            end
        end
    end

    assign w_done_next = r_done | (w_sel & in_last);
    assign w_round_end = &w_done_next;

    assign in_ready = w_pop ? w_sel : '0;

    // ------------------------------------------------------------------
    // Output register and per-lane end-of-stream flags
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_done      <= '0;
            r_out_valid <= 1'b0;
            r_out_coord <= '0;
            r_out_value <= '0;
            r_out_last  <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_coord <= w_min;
            r_out_value <= w_sum;
            if (w_round_end) begin
                // Closing the round clears all flags so the next round
                // begins on the following cycle with every lane active.
                r_out_last <= 1'b1;
                r_done     <= '0;
            end else begin
                r_out_last <= 1'b0;
                r_done     <= w_done_next;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_coord = r_out_coord;
    assign out_value = r_out_value;
    assign out_last  = r_out_last;
    assign busy      = |r_done;

endmodule
`default_nettype wire
